// File: rtl/online_softmax_stage_pkg.sv
// Shared types and constants for the online-softmax stage that sits behind dot_product.
// Scores are Q7.5, exp weights are Q1.8 (256 = 1.0), and the denominator is unsigned Q8.8.
package online_softmax_stage_pkg;

  localparam int MAX_EMBEDDING_DIM = 4;
  localparam int V_ELEM_W          = 16;
  localparam int SCORE_W           = 13;
  localparam int DIFF_W            = SCORE_W + 1;
  localparam int EXP_W             = 9;
  localparam int EXP_LUT_DEPTH_DEF = 256;
  localparam int SUM_W_DEF         = 16;

  typedef logic signed [SCORE_W-1:0]                   score_qt_t;
  typedef logic [EXP_W-1:0]                            exp_qt_t;
  typedef logic [SUM_W_DEF-1:0]                        sum_qt_t;
  typedef logic [DIFF_W-1:0]                           diff_t;
  typedef logic [MAX_EMBEDDING_DIM-1:0][V_ELEM_W-1:0]  v_vector_t;

  localparam score_qt_t SCORE_NEG_INF = score_qt_t'(-4096);
  localparam exp_qt_t   EXP_ONE       = exp_qt_t'(256);

  // exp(-1/32) in Q48, from a truncated Taylor series; one LUT step is one score LSB.
  function automatic logic [127:0] exp_step_q48();
    logic [127:0] acc;
    logic [127:0] term;
    acc  = 128'd1 << 48;
    term = acc;
    for (int k = 1; k <= 12; k++) begin
      term = term / 128'(32 * k);
      if (k % 2 == 1) acc = acc - term;
      else            acc = acc + term;
    end
    return acc;
  endfunction

endpackage

// File: rtl/online_softmax_stage_if.sv
// Score/V input stream and weighted output stream of the online-softmax stage.
// The slave modport is the stage's own view; the master modport is the surrounding logic's view.
interface online_softmax_stage_if #(
  parameter int DIM   = online_softmax_stage_pkg::MAX_EMBEDDING_DIM,
  parameter int SUM_W = online_softmax_stage_pkg::SUM_W_DEF
);
  import online_softmax_stage_pkg::*;

  logic                          vld_in;
  logic                          rdy_out;
  score_qt_t                     s_in;
  logic [DIM-1:0][V_ELEM_W-1:0]  v_in;
  logic                          last_in;

  logic                          vld_out;
  logic                          rdy_in;
  exp_qt_t                       p_out;
  exp_qt_t                       scale_out;
  logic [DIM-1:0][V_ELEM_W-1:0]  v_out;
  logic [SUM_W-1:0]              l_out;
  logic                          last_out;

  modport slave (
    input  vld_in, s_in, v_in, last_in, rdy_in,
    output rdy_out, vld_out, p_out, scale_out, v_out, l_out, last_out
  );

  modport master (
    output vld_in, s_in, v_in, last_in, rdy_in,
    input  rdy_out, vld_out, p_out, scale_out, v_out, l_out, last_out
  );

endinterface

// File: rtl/online_softmax_stage_exp_lut.sv
// Combinational ROM: y = round(256 * exp(-x/32)) for x < DEPTH, else 0.
// The table is built at elaboration from a fixed-point power series, so no external init file.
module online_softmax_stage_exp_lut
  import online_softmax_stage_pkg::*;
#(
  parameter int DEPTH = EXP_LUT_DEPTH_DEF
) (
  input  diff_t   x,
  output exp_qt_t y
);

  localparam int IDX_W = $clog2(DEPTH);

  function automatic logic [DEPTH-1:0][EXP_W-1:0] build_table();
    logic [127:0]                  r;
    logic [127:0]                  v;
    logic [127:0]                  e;
    logic [DEPTH-1:0][EXP_W-1:0]   t;
    r = exp_step_q48();
    v = 128'd1 << 48;
    for (int i = 0; i < DEPTH; i++) begin
      e    = ((v << 8) + (128'd1 << 47)) >> 48;
      t[i] = e[EXP_W-1:0];
      v    = (v * r) >> 48;
    end
    return t;
  endfunction

  localparam logic [DEPTH-1:0][EXP_W-1:0] TABLE = build_table();

  // NOTE: y gets its default before the branch so no path leaves it unassigned (no latch).
  always_comb begin
    y = '0;
    if (int'(x) < DEPTH) y = TABLE[x[IDX_W-1:0]];
  end

endmodule

// File: rtl/online_softmax_stage.sv
// FlashAttention online-softmax stage: tracks the row max and running denominator, and emits
// p = exp(s - m_new), the accumulator rescale exp(m_old - m_new) and the paired V row.
module online_softmax_stage
  import online_softmax_stage_pkg::*;
#(
  parameter int DIM           = MAX_EMBEDDING_DIM,
  parameter int EXP_LUT_DEPTH = EXP_LUT_DEPTH_DEF,
  parameter int SUM_W         = SUM_W_DEF
) (
  input logic                   clk,
  input logic                   rst,
  online_softmax_stage_if.slave io
);

  typedef logic [DIM-1:0][V_ELEM_W-1:0] v_row_t;

  // Row state
  score_qt_t m_q;
  logic      row_first;
  score_qt_t m_new;
  diff_t     dp_next;
  diff_t     dsc_next;
  logic      accept;

  // S1
  logic   s1_vld;
  logic   s1_adv;
  diff_t  s1_dp;
  diff_t  s1_dsc;
  logic   s1_first;
  logic   s1_last;
  v_row_t s1_v;

  // S2 (drives the outputs)
  logic             s2_vld;
  exp_qt_t          s2_p;
  exp_qt_t          s2_scale;
  v_row_t           s2_v;
  logic [SUM_W-1:0] s2_l;
  logic             s2_last;

  exp_qt_t                  p_lut;
  exp_qt_t                  sc_lut;
  exp_qt_t                  scale_next;
  logic [SUM_W+EXP_W-1:0]   prod;
  logic [SUM_W+1:0]         acc_sum;
  logic [SUM_W-1:0]         l_next;

  assign s1_adv     = s1_vld && (!s2_vld || io.rdy_in);
  assign io.rdy_out = rst && (!s1_vld || s1_adv);
  assign accept     = io.vld_in && io.rdy_out;

  // The new max comes straight off the registered m, so consecutive scores never see a stale max.
  always_comb begin
    m_new = io.s_in;
    if (!row_first && (m_q > io.s_in)) m_new = m_q;
    dp_next  = {m_new[SCORE_W-1], m_new} - {io.s_in[SCORE_W-1], io.s_in};
    dsc_next = {m_new[SCORE_W-1], m_new} - {m_q[SCORE_W-1], m_q};
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      m_q       <= SCORE_NEG_INF;
      row_first <= 1'b1;
      s1_vld    <= 1'b0;
    end else begin
      if (accept) begin
        m_q       <= m_new;
        row_first <= io.last_in;
      end
      if (accept)      s1_vld <= 1'b1;
      else if (s1_adv) s1_vld <= 1'b0;
    end
  end

  // NOTE: S1 payload is qualified by s1_vld, so it is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_dp    <= dp_next;
      s1_dsc   <= dsc_next;
      s1_first <= row_first;
      s1_last  <= io.last_in;
      s1_v     <= io.v_in;
    end
  end

  online_softmax_stage_exp_lut #(.DEPTH(EXP_LUT_DEPTH)) u_lut_p (
    .x (s1_dp),
    .y (p_lut)
  );

  online_softmax_stage_exp_lut #(.DEPTH(EXP_LUT_DEPTH)) u_lut_scale (
    .x (s1_dsc),
    .y (sc_lut)
  );

  // l' = (l * scale) >> 8 + p, truncating the shift and saturating at all-ones.
  always_comb begin
    scale_next = s1_first ? '0 : sc_lut;
    prod       = (SUM_W+EXP_W)'(s2_l) * (SUM_W+EXP_W)'(scale_next);
    acc_sum    = (SUM_W+2)'(prod >> 8) + (SUM_W+2)'(p_lut);
    if (s1_first)                      l_next = SUM_W'(p_lut);
    else if (|acc_sum[SUM_W+1:SUM_W])  l_next = '1;
    else                               l_next = acc_sum[SUM_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s2_vld   <= 1'b0;
      s2_p     <= '0;
      s2_scale <= '0;
      s2_v     <= '0;
      s2_l     <= '0;
      s2_last  <= 1'b0;
    end else if (s1_adv) begin
      s2_vld   <= 1'b1;
      s2_p     <= p_lut;
      s2_scale <= scale_next;
      s2_v     <= s1_v;
      s2_l     <= l_next;
      s2_last  <= s1_last;
    end else if (io.rdy_in) begin
      s2_vld   <= 1'b0;
    end
  end

  assign io.vld_out   = s2_vld;
  assign io.p_out     = s2_p;
  assign io.scale_out = s2_scale;
  assign io.v_out     = s2_v;
  assign io.l_out     = s2_l;
  assign io.last_out  = s2_last;

endmodule

// File: tb/tb_online_softmax_stage.sv
// Directed bench for online_softmax_stage: hand-computed p/scale/l vectors per scenario,
// with a negedge monitor collecting every output transfer in order.
module tb_online_softmax_stage;
  import online_softmax_stage_pkg::*;

  typedef struct packed {
    exp_qt_t   p;
    exp_qt_t   scale;
    sum_qt_t   l;
    logic      last;
    v_vector_t v;
  } beat_t;

  logic  clk = 1'b0;
  logic  rst = 1'b0;
  int    n_checks = 0;
  int    n_fail   = 0;
  int    acc_cnt  = 0;
  bit    sender_done;
  beat_t obs_q[$];

  online_softmax_stage_if #(.DIM(MAX_EMBEDDING_DIM), .SUM_W(SUM_W_DEF)) bus ();

  online_softmax_stage #(
    .DIM           (MAX_EMBEDDING_DIM),
    .EXP_LUT_DEPTH (EXP_LUT_DEPTH_DEF),
    .SUM_W         (SUM_W_DEF)
  ) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  always #5 clk = ~clk;

  function automatic beat_t capture();
    beat_t b;
    b.p     = bus.p_out;
    b.scale = bus.scale_out;
    b.l     = bus.l_out;
    b.last  = bus.last_out;
    b.v     = bus.v_out;
    return b;
  endfunction

  // Transfers happen at the next posedge; inputs only change at posedge+1.
  always @(negedge clk) begin
    if (rst && bus.vld_out && bus.rdy_in) obs_q.push_back(capture());
    if (bus.vld_in && bus.rdy_out) acc_cnt++;
  end

  function automatic v_vector_t mk_v(input int seed);
    v_vector_t v;
    for (int i = 0; i < MAX_EMBEDDING_DIM; i++) v[i] = 16'(seed * 16 + i);
    return v;
  endfunction

  function automatic beat_t mk(input int p, input int sc, input int l, input logic last,
                               input v_vector_t v);
    beat_t b;
    b.p     = exp_qt_t'(p);
    b.scale = exp_qt_t'(sc);
    b.l     = sum_qt_t'(l);
    b.last  = last;
    b.v     = v;
    return b;
  endfunction

  function automatic string fmt(input beat_t b);
    return $sformatf("p=%0d scale=%0d l=%0d last=%0b v=%h", b.p, b.scale, b.l, b.last, b.v);
  endfunction

  task automatic send(input int s, input logic last, input v_vector_t v);
    n_checks++;
    bus.vld_in  = 1'b1;
    bus.s_in    = score_qt_t'(s);
    bus.last_in = last;
    bus.v_in    = v;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (bus.rdy_out === 1'b1) begin
        @(posedge clk); #1;
        return;
      end
    end
    n_fail++;
    $display("FAIL send_timeout: score %0d got no accept in 64 cycles, want accept", s);
    bus.vld_in = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    bus.vld_in  = 1'b0;
    bus.last_in = 1'b0;
  endtask

  task automatic wait_beats(input int target, input string name);
    n_checks++;
    for (int i = 0; i < 100; i++) begin
      if (obs_q.size() >= target) return;
      @(posedge clk); #1;
    end
    n_fail++;
    $display("FAIL %s_beats: got %0d beats, want %0d", name, obs_q.size(), target);
  endtask

  task automatic test_reset();
    rst         = 1'b0;
    bus.vld_in  = 1'b0;
    bus.rdy_in  = 1'b1;
    bus.s_in    = '0;
    bus.v_in    = '0;
    bus.last_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (bus.vld_out !== 1'b0) begin
      n_fail++; $display("FAIL reset_vld_out: got %b, want 0", bus.vld_out);
    end
    n_checks++;
    if (capture() !== beat_t'('0)) begin
      n_fail++; $display("FAIL reset_outputs: got %s, want all zero", fmt(capture()));
    end
    n_checks++;
    if (bus.rdy_out !== 1'b0) begin
      n_fail++; $display("FAIL reset_rdy_out: got %b, want 0", bus.rdy_out);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (bus.rdy_out !== 1'b1 || bus.vld_out !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: got rdy_out=%b vld_out=%b, want 1 0", bus.rdy_out, bus.vld_out);
    end
  endtask

  task automatic test_single_row();
    beat_t want;
    want = mk(256, 0, 256, 1'b1, mk_v(1));
    send(100, 1'b1, mk_v(1));
    idle();
    n_checks++;
    if (bus.vld_out !== 1'b0) begin
      n_fail++; $display("FAIL single_latency_early: got vld_out=%b, want 0", bus.vld_out);
    end
    @(posedge clk); #1;
    n_checks++;
    if (bus.vld_out !== 1'b1 || capture() !== want) begin
      n_fail++;
      $display("FAIL single_beat: got vld=%b %s, want vld=1 %s", bus.vld_out, fmt(capture()),
               fmt(want));
    end
    @(posedge clk); #1;
    n_checks++;
    if (bus.vld_out !== 1'b0) begin
      n_fail++; $display("FAIL single_drain: got vld_out=%b, want 0", bus.vld_out);
    end
  endtask

  task automatic test_rising_max();
    int    base;
    beat_t got;
    beat_t want[3];
    base    = obs_q.size();
    want[0] = mk(256, 0,   256, 1'b0, mk_v(2));
    want[1] = mk(256, 94,  350, 1'b0, mk_v(3));
    want[2] = mk(94,  256, 444, 1'b1, mk_v(4));
    send(0,  1'b0, mk_v(2));
    send(32, 1'b0, mk_v(3));
    send(0,  1'b1, mk_v(4));
    idle();
    wait_beats(base + 3, "rising");
    for (int i = 0; i < 3; i++) begin
      got = (obs_q.size() > base + i) ? obs_q[base + i] : beat_t'('0);
      n_checks++;
      if (obs_q.size() <= base + i || got !== want[i]) begin
        n_fail++; $display("FAIL rising beat %0d: got %s, want %s", i, fmt(got), fmt(want[i]));
      end
    end
  endtask

  task automatic test_lut_saturation();
    int    base;
    beat_t got;
    beat_t want[2];
    base    = obs_q.size();
    want[0] = mk(256, 0,   256, 1'b0, mk_v(5));
    want[1] = mk(0,   256, 256, 1'b1, mk_v(6));
    send(4064,  1'b0, mk_v(5));
    send(-4096, 1'b1, mk_v(6));
    idle();
    wait_beats(base + 2, "lut_sat");
    for (int i = 0; i < 2; i++) begin
      got = (obs_q.size() > base + i) ? obs_q[base + i] : beat_t'('0);
      n_checks++;
      if (obs_q.size() <= base + i || got !== want[i]) begin
        n_fail++; $display("FAIL lut_sat beat %0d: got %s, want %s", i, fmt(got), fmt(want[i]));
      end
    end
  endtask

  task automatic test_backpressure();
    int    base;
    int    acc_base;
    beat_t got;
    beat_t want[3];
    base        = obs_q.size();
    acc_base    = acc_cnt;
    want[0]     = mk(256, 0,   256, 1'b0, mk_v(7));
    want[1]     = mk(94,  256, 350, 1'b0, mk_v(8));
    want[2]     = mk(256, 94,  384, 1'b1, mk_v(9));
    sender_done = 1'b0;
    bus.rdy_in  = 1'b0;
    fork
      begin
        send(32, 1'b0, mk_v(7));
        send(0,  1'b0, mk_v(8));
        send(64, 1'b1, mk_v(9));
        idle();
        sender_done = 1'b1;
      end
    join_none
    repeat (2) @(negedge clk);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_checks++;
      if (bus.vld_out !== 1'b1 || bus.rdy_out !== 1'b0 || capture() !== want[0]) begin
        n_fail++;
        $display("FAIL stall_hold cycle %0d: got vld=%b rdy_out=%b %s, want vld=1 rdy_out=0 %s",
                 c, bus.vld_out, bus.rdy_out, fmt(capture()), fmt(want[0]));
      end
    end
    n_checks++;
    if (acc_cnt - acc_base !== 2 || obs_q.size() !== base) begin
      n_fail++;
      $display("FAIL stall_accepts: got accepts=%0d beats=%0d, want accepts=2 beats=0",
               acc_cnt - acc_base, obs_q.size() - base);
    end
    @(posedge clk); #1;
    bus.rdy_in = 1'b1;
    n_checks++;
    for (int i = 0; i < 100 && !sender_done; i++) begin
      @(posedge clk); #1;
    end
    if (!sender_done) begin
      n_fail++; $display("FAIL drain_sender: got sender stuck, want all 3 accepted");
    end
    wait_beats(base + 3, "drain");
    repeat (4) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      got = (obs_q.size() > base + i) ? obs_q[base + i] : beat_t'('0);
      n_checks++;
      if (obs_q.size() <= base + i || got !== want[i]) begin
        n_fail++; $display("FAIL drain beat %0d: got %s, want %s", i, fmt(got), fmt(want[i]));
      end
    end
    n_checks++;
    if (obs_q.size() !== base + 3 || acc_cnt - acc_base !== 3) begin
      n_fail++;
      $display("FAIL drain_count: got beats=%0d accepts=%0d, want 3 3",
               obs_q.size() - base, acc_cnt - acc_base);
    end
  endtask

  task automatic test_row_boundary();
    int    base;
    beat_t got;
    beat_t want[3];
    base    = obs_q.size();
    want[0] = mk(256, 0,  256, 1'b1, mk_v(10));
    want[1] = mk(256, 0,  256, 1'b0, mk_v(11));
    want[2] = mk(256, 94, 350, 1'b1, mk_v(12));
    send(64,  1'b1, mk_v(10));
    send(-64, 1'b0, mk_v(11));
    send(-32, 1'b1, mk_v(12));
    idle();
    wait_beats(base + 3, "row_boundary");
    for (int i = 0; i < 3; i++) begin
      got = (obs_q.size() > base + i) ? obs_q[base + i] : beat_t'('0);
      n_checks++;
      if (obs_q.size() <= base + i || got !== want[i]) begin
        n_fail++;
        $display("FAIL row_boundary beat %0d: got %s, want %s", i, fmt(got), fmt(want[i]));
      end
    end
  endtask

  task automatic test_reset_mid_row();
    int    base;
    beat_t got;
    beat_t want;
    base = obs_q.size();
    want = mk(256, 0, 256, 1'b1, mk_v(14));
    send(64, 1'b0, mk_v(13));
    idle();
    rst = 1'b0;
    #1;
    n_checks++;
    if (bus.vld_out !== 1'b0 || bus.rdy_out !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_during: got vld_out=%b rdy_out=%b, want 0 0", bus.vld_out, bus.rdy_out);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    n_checks++;
    if (bus.vld_out !== 1'b0) begin
      n_fail++; $display("FAIL midrst_after: got vld_out=%b, want 0", bus.vld_out);
    end
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (obs_q.size() !== base) begin
      n_fail++; $display("FAIL midrst_flush: got %0d beats, want 0", obs_q.size() - base);
    end
    send(0, 1'b1, mk_v(14));
    idle();
    wait_beats(base + 1, "midrst");
    got = (obs_q.size() > base) ? obs_q[base] : beat_t'('0);
    n_checks++;
    if (obs_q.size() <= base || got !== want) begin
      n_fail++; $display("FAIL midrst_beat: got %s, want %s", fmt(got), fmt(want));
    end
  endtask

  initial begin
    test_reset();
    test_single_row();
    test_rising_max();
    test_lut_saturation();
    test_backpressure();
    test_row_boundary();
    test_reset_mid_row();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200us, want finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/online_softmax_stage.md
Name: online_softmax_stage

Overview:
- Sits directly downstream of dot_product; consumes its scaled score (SCORE_QT) and the V vector forwarded alongside it.
- Maintains the per-row running maximum and running softmax denominator for FlashAttention.
- Emits, per score:
  - the exponent weight p = exp(s − m_new);
  - the rescale factor exp(m_old − m_new) for the downstream P·V accumulator;
  - the V vector.
- Row boundaries are marked by last_in.

Parameters:
- DIM, `MAX_EMBEDDING_DIM, elements per V vector (pass-through only).
- EXP_LUT_DEPTH, 256, exp LUT entries; index is the difference in SCORE_QT LSBs (Q.5); the LUT covers 0 ≤ x < 8.0.
- SUM_W, 16, width of the running denominator, unsigned Q8.8.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset (rst==0 resets on the clk edge).
- vld_in  in  1  score/V valid, from dot_product vld_out.
- rdy_out  out  1  ready to accept, to dot_product rdy_in.
- s_in  in  SCORE_QT (13b signed Q7.5)  scaled score.
- v_in  in  V_VECTOR_T  V row paired with s_in.
- last_in  in  1  this score is the final key of the current query row.
- vld_out  out  1  output beat valid.
- rdy_in  in  1  downstream ready.
- p_out  out  EXP_QT (9b unsigned Q1.8)  exp(s − m_new); 256 = 1.0.
- scale_out  out  EXP_QT  exp(m_old − m_new); 0 on the first element of a row.
- v_out  out  V_VECTOR_T  delayed v_in.
- l_out  out  SUM_W  running denominator including this element.
- last_out  out  1  delayed last_in.

Behaviour:
- Handshakes:
  - An input transfer occurs on a cycle with vld_in && rdy_out.
  - An output transfer occurs on a cycle with vld_out && rdy_in.
  - The producer must hold s_in, v_in and last_in stable while vld_in is high and rdy_out is low.
  - While vld_out is high and rdy_in is low, all outputs hold their values.
- Pipeline: 2 register stages, S1 and S2 (S2 drives the outputs).
  - Each stage advances when it is empty or the stage after it advances.
  - rdy_out = rst && (!s1_vld || s1_adv). This is combinational.
  - Latency is 2 cycles from input transfer to vld_out, with no stalls. Throughput is 1 per cycle.
- Max state: m (SCORE_QT) and first flag (row_first).
  - On reset: m = −4096, row_first = 1.
  - On transfer: m_new = row_first ? s : max(m, s).
  - m ← m_new. row_first ← last_in.
  - m is updated at acceptance (combinational from the registered m), so back-to-back scores within a row are handled without hazard.
- S1 registers:
  - d_p = m_new − s (≥0, 14b).
  - d_sc = m_new − m_old (≥0, 14b).
  - first, v, last.
- S2 lookup: LUT(x) = round(256·exp(−x/32)) for x < EXP_LUT_DEPTH; 0 for x ≥ EXP_LUT_DEPTH. LUT(0) = 256.
  - p = LUT(d_p).
  - scale = first ? 0 : LUT(d_sc).
- Denominator register l (SUM_W), updated when S2 loads:
  - l ← first ? p : ((l·scale) >> 8) + p.
  - Saturates at 2^SUM_W − 1. Truncate the >> 8; do not round.
  - l_out = the updated l.
- Reset values: vld_out=0, p_out=0, scale_out=0, v_out=0, l_out=0, last_out=0. All pipeline valids are 0, m=−4096, row_first=1, l=0.
- Reset mid-operation: in-flight beats are discarded. The next accepted score is treated as the first element of a row.
- The diff computation is in 14b, so m − s never overflows at the extremes (127.97 − (−128)).
- Simultaneous events: a cycle with an S2 output transfer and an S1→S2 load at the same time is legal. Likewise an input accept at the same time as S1→S2 is legal.
- last_in=1 on a single-element row is legal. Output is p=256, scale=0, l=256.

Decomposition:
- Shared package (sys_defs), new additions:
  - EXP_QT: 9b unsigned Q1.8.
  - SUM_QT: SUM_W-bit unsigned.
  - `EXP_LUT_DEPTH.
  - `SCORE_NEG_INF = −4096.
- SCORE_QT and V_VECTOR_T come from the existing package.
- One sub-module: exp_lut. It is a combinational ROM mapping a 14b non-negative difference to EXP_QT, with saturation to 0 beyond the table. It is instantiated twice (p and scale).

Test Plan:
- Single-element row: s=100 (3.125), last=1 → p=256, scale=0, l_out=256, last_out=1, 2 cycles after accept.
- Rising max: scores 0, 32, 0 (last on the third), back-to-back with rdy_in=1 →
  - beat 1: p=256, scale=0, l=256;
  - beat 2: p=256, scale=94, l=350;
  - beat 3: p=94, scale=256, l=444.
- LUT saturation: s=127 then s=−128 in the same row → second beat: p=0 (d_p ≥ 256), scale=256, l=256.
- Backpressure: rdy_in=0 while 3 scores are offered.
  - vld_out rises, and the outputs hold stably.
  - rdy_out drops after 2 accepts.
  - Releasing rdy_in drains all 3 in order with correct values and no duplicate or lost beats.
- Row boundary: row A = {64}, last; row B = {−64} → second beat has scale=0, p=256, l=256. B's max is not contaminated by A.
- Reset mid-row: accept s=64, assert rst=0 for 1 cycle, then s=0 →
  - vld_out=0 during reset;
  - the post-reset beat has scale=0, p=256, l=256.
